hs_counter_stream: RTL and testbench

Parametrised valid/ready counter generator, the successor to the single-token increment-and-loop handshake counter. It produces a stream of count values with a runtime start value, step and limit, modulo wrap, and a continuous or one-shot mode. Values are buffered in a DEPTH-entry elastic FIFO so a stalled consumer never loses or duplicates a value. It sits at the head of test and datapath pipelines as a sequence or address source.

---
 rtl/hs_counter_stream.sv | 122 ++++++++++++
 tb/tb_hs_counter_stream.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hs_counter_stream.sv
// Valid/ready counter stream: runtime start/step/limit with modulo wrap,
// continuous or one-shot mode, and a DEPTH-entry output FIFO.
module hs_counter_stream #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       one_shot,
    input  logic [WIDTH-1:0]           start_val,
    input  logic [WIDTH-1:0]           step,
    input  logic [WIDTH-1:0]           limit,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_wrap,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic               r_one_shot;
    logic [WIDTH-1:0]   r_step;
    logic [WIDTH-1:0]   r_limit;
    logic [WIDTH-1:0]   r_next;
    logic               r_pend_wrap;

    logic [WIDTH-1:0]   r_mem_data [DEPTH];
    logic               r_mem_wrap [DEPTH];
    logic [PW-1:0]      r_rd_ptr;
    logic [PW-1:0]      r_wr_ptr;
    logic [LW-1:0]      r_level;

    logic               w_pop;
    logic               w_full;
    logic               w_push;
    logic [WIDTH:0]     w_sum;
    logic               w_over;
    logic [WIDTH-1:0]   w_wrapped;
    logic               w_os_end;

    assign w_pop     = out_valid && out_ready;
    assign w_full    = (r_level == LW'(DEPTH));
    assign w_push    = (r_state == S_RUN) && !stop && (!w_full || w_pop);
    assign w_sum     = {1'b0, r_next} + {1'b0, r_step};
    assign w_over    = w_sum > {1'b0, r_limit};
    // Modulo arithmetic makes the truncated subtraction equal sum-(limit+1).
    assign w_wrapped = w_sum[WIDTH-1:0] - r_limit - WIDTH'(1);
    assign w_os_end  = w_push && w_over && r_one_shot;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (stop || w_os_end) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_level == '0) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_one_shot  <= 1'b0;
            r_step      <= '0;
            r_limit     <= '0;
            r_next      <= '0;
            r_pend_wrap <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == S_IDLE && start) begin
                r_one_shot  <= one_shot;
                r_step      <= step;
                r_limit     <= limit;
                r_next      <= start_val;
                r_pend_wrap <= 1'b0;
            end else if (w_push && !w_os_end) begin
                r_next      <= w_over ? w_wrapped : w_sum[WIDTH-1:0];
                r_pend_wrap <= w_over;
            end
        end
    end

    // Storage needs no reset: unread entries are masked by out_valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_next;
            r_mem_wrap[r_wr_ptr] <= r_pend_wrap;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH-1)) ? '0 : r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH-1)) ? '0 : r_rd_ptr + PW'(1);
            if (w_push && !w_pop)
                r_level <= r_level + LW'(1);
            else if (w_pop && !w_push)
                r_level <= r_level - LW'(1);
        end
    end

    assign out_valid = (r_level != '0);
    assign out_data  = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_wrap  = out_valid ? r_mem_wrap[r_rd_ptr] : 1'b0;
    assign busy      = (r_state != S_IDLE);
    assign level     = r_level;
endmodule

// File: tb/tb_hs_counter_stream.sv
// Directed bench for hs_counter_stream: three instances (DEPTH 4, 8, 1)
// share configuration inputs and have their own start/stop/ready.
module tb_hs_counter_stream;
    logic       clk;
    logic       rst_n;
    logic       one_shot;
    logic [7:0] start_val, step, limit;

    logic       start_a, stop_a, rdy_a, wrap_a, valid_a, busy_a;
    logic [7:0] data_a;
    logic [2:0] level_a;
    logic       start_b, stop_b, rdy_b, wrap_b, valid_b, busy_b;
    logic [7:0] data_b;
    logic [3:0] level_b;
    logic       start_c, stop_c, rdy_c, wrap_c, valid_c, busy_c;
    logic [7:0] data_c;
    logic [0:0] level_c;

    int checks = 0;
    int errors = 0;

    hs_counter_stream #(.WIDTH(8), .DEPTH(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .one_shot(one_shot),
        .start_val(start_val), .step(step), .limit(limit),
        .out_data(data_a), .out_wrap(wrap_a), .out_valid(valid_a), .out_ready(rdy_a),
        .busy(busy_a), .level(level_a));

    hs_counter_stream #(.WIDTH(8), .DEPTH(8)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .one_shot(one_shot),
        .start_val(start_val), .step(step), .limit(limit),
        .out_data(data_b), .out_wrap(wrap_b), .out_valid(valid_b), .out_ready(rdy_b),
        .busy(busy_b), .level(level_b));

    hs_counter_stream #(.WIDTH(8), .DEPTH(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .stop(stop_c), .one_shot(one_shot),
        .start_val(start_val), .step(step), .limit(limit),
        .out_data(data_c), .out_wrap(wrap_c), .out_valid(valid_c), .out_ready(rdy_c),
        .busy(busy_c), .level(level_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic os, input logic [7:0] sv, input logic [7:0] st,
                           input logic [7:0] lim);
        one_shot  = os;
        start_val = sv;
        step      = st;
        limit     = lim;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (valid_a !== 1'b0 || data_a !== 8'd0 || wrap_a !== 1'b0 || busy_a !== 1'b0 || level_a !== 3'd0) begin
            errors++;
            $display("FAIL reset_values: valid=%0b data=%0d wrap=%0b busy=%0b level=%0d want all 0",
                     valid_a, data_a, wrap_a, busy_a, level_a);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0 || busy_b !== 1'b0 || busy_c !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy a/b/c=%0b%0b%0b valid=%0b want 0",
                     busy_a, busy_b, busy_c, valid_a);
        end
    endtask

    task automatic test_continuous();
        logic [7:0] exp_d [8];
        logic       exp_w [8];
        int         n;
        exp_d = '{8'd0, 8'd3, 8'd6, 8'd9, 8'd2, 8'd5, 8'd8, 8'd1};
        exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        set_cfg(1'b0, 8'd0, 8'd3, 8'd9);
        rdy_a   = 1'b1;
        start_a = 1'b1;
        stop_a  = 1'b1;   // start wins in IDLE
        tick();
        start_a = 1'b0;
        stop_a  = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL cont_start_edge: busy=%0b valid=%0b want busy=1 valid=0", busy_a, valid_a);
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (valid_a !== 1'b1 || data_a !== exp_d[i] || wrap_a !== exp_w[i] || level_a > 3'd1) begin
                errors++;
                $display("FAIL cont_value[%0d]: valid=%0b data=%0d wrap=%0b level=%0d want valid=1 data=%0d wrap=%0b level<=1",
                         i, valid_a, data_a, wrap_a, level_a, exp_d[i], exp_w[i]);
            end
            tick();
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0 || n != 1) begin
            errors++;
            $display("FAIL cont_stop_idle: busy=%0b valid=%0b drain_cycles=%0d want 0 0 1", busy_a, valid_a, n);
        end
    endtask

    task automatic test_one_shot();
        logic [7:0] got [16];
        int         cnt;
        int         last_k;
        int         idle_k;
        logic       saw_wrap;
        cnt = 0; last_k = -1; idle_k = -1; saw_wrap = 1'b0;
        set_cfg(1'b1, 8'd0, 8'd3, 8'd9);
        rdy_a   = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (valid_a === 1'b1 && cnt < 16) begin
                got[cnt] = data_a;
                saw_wrap = saw_wrap | wrap_a;
                cnt++;
                last_k = k;
            end
            if (busy_a === 1'b0 && idle_k < 0) idle_k = k;
            tick();
        end
        checks++;
        if (cnt != 4) begin
            errors++;
            $display("FAIL oneshot_count: got %0d values want 4", cnt);
        end else begin
            checks++;
            if (got[0] !== 8'd0 || got[1] !== 8'd3 || got[2] !== 8'd6 || got[3] !== 8'd9 || saw_wrap) begin
                errors++;
                $display("FAIL oneshot_values: got %0d,%0d,%0d,%0d wrapflag=%0b want 0,3,6,9 wrapflag=0",
                         got[0], got[1], got[2], got[3], saw_wrap);
            end
        end
        checks++;
        if (last_k != 4 || idle_k != last_k + 2) begin
            errors++;
            $display("FAIL oneshot_busy_fall: last_pop_sample=%0d idle_sample=%0d want 4 and 6", last_k, idle_k);
        end
    endtask

    task automatic test_backpressure();
        int n;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd255);
        rdy_a   = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            checks++;
            if (valid_a !== 1'b1 || data_a !== 8'd0) begin
                errors++;
                $display("FAIL bp_stall_head[%0d]: valid=%0b data=%0d want 1 0", c, valid_a, data_a);
            end
        end
        checks++;
        if (level_a !== 3'd4) begin
            errors++;
            $display("FAIL bp_level_sat: level=%0d want 4", level_a);
        end
        rdy_a = 1'b1;
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (valid_a !== 1'b1 || data_a !== 8'(i) || wrap_a !== 1'b0) begin
                errors++;
                $display("FAIL bp_resume[%0d]: valid=%0b data=%0d wrap=%0b want 1 %0d 0",
                         i, valid_a, data_a, wrap_a, i);
            end
            tick();
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain_timeout: busy=%0b want 0", busy_a);
        end
    endtask

    task automatic test_stop_mid_run();
        logic [7:0] got [16];
        int         cnt;
        logic       ok;
        cnt = 0;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd255);
        rdy_b   = 1'b0;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (level_b !== 4'd5) begin
            errors++;
            $display("FAIL stop_fill_level: level=%0d want 5", level_b);
        end
        stop_b = 1'b1;
        tick();
        stop_b = 1'b0;
        checks++;
        if (level_b !== 4'd5 || busy_b !== 1'b1) begin
            errors++;
            $display("FAIL stop_no_push: level=%0d busy=%0b want 5 1", level_b, busy_b);
        end
        rdy_b   = 1'b1;
        start_b = 1'b1;   // lands in DRAIN and must be ignored
        for (int n = 0; n < 16; n++) begin
            if (valid_b === 1'b1 && cnt < 16) begin
                got[cnt] = data_b;
                cnt++;
            end
            tick();
            start_b = 1'b0;
        end
        checks++;
        if (cnt != 5) begin
            errors++;
            $display("FAIL stop_drain_count: got %0d values want 5", cnt);
        end else begin
            ok = 1'b1;
            for (int i = 0; i < 5; i++) if (got[i] !== 8'(i)) ok = 1'b0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stop_drain_values: got %0d,%0d,%0d,%0d,%0d want 0,1,2,3,4",
                         got[0], got[1], got[2], got[3], got[4]);
            end
        end
        checks++;
        if (busy_b !== 1'b0 || valid_b !== 1'b0) begin
            errors++;
            $display("FAIL stop_idle: busy=%0b valid=%0b want 0 0", busy_b, valid_b);
        end
    endtask

    task automatic test_full_pop();
        logic [7:0] exp_v;
        int         n;
        exp_v = 8'd5;
        set_cfg(1'b0, 8'd5, 8'd7, 8'd250);
        rdy_c   = 1'b0;
        start_c = 1'b1;
        tick();
        start_c = 1'b0;
        tick();
        for (int i = 0; i < 30; i++) begin
            rdy_c = 1'($urandom_range(0, 1));
            checks++;
            if (valid_c !== 1'b1 || level_c !== 1'b1 || data_c !== exp_v) begin
                errors++;
                $display("FAIL full_pop[%0d]: valid=%0b level=%0d data=%0d want 1 1 %0d",
                         i, valid_c, level_c, data_c, exp_v);
            end
            if (rdy_c) exp_v = exp_v + 8'd7;
            tick();
        end
        rdy_c  = 1'b1;
        stop_c = 1'b1;
        tick();
        stop_c = 1'b0;
        n = 0;
        while (busy_c === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (busy_c !== 1'b0 || valid_c !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_idle: busy=%0b valid=%0b want 0 0", busy_c, valid_c);
        end
    endtask

    task automatic test_async_reset();
        int n;
        set_cfg(1'b0, 8'd0, 8'd1, 8'd255);
        rdy_a   = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        tick();
        checks++;
        if (level_a !== 3'd2) begin
            errors++;
            $display("FAIL arst_pre_level: level=%0d want 2", level_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (valid_a !== 1'b0 || data_a !== 8'd0 || wrap_a !== 1'b0 || busy_a !== 1'b0 || level_a !== 3'd0) begin
            errors++;
            $display("FAIL arst_immediate: valid=%0b data=%0d wrap=%0b busy=%0b level=%0d want all 0",
                     valid_a, data_a, wrap_a, busy_a, level_a);
        end
        tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy_a !== 1'b0 || valid_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_release_idle: busy=%0b valid=%0b want 0 0", busy_a, valid_a);
        end
        set_cfg(1'b0, 8'd40, 8'd1, 8'd255);
        rdy_a   = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'd40) begin
            errors++;
            $display("FAIL arst_restart_first: valid=%0b data=%0d want 1 40", valid_a, data_a);
        end
        tick();
        checks++;
        if (valid_a !== 1'b1 || data_a !== 8'd41) begin
            errors++;
            $display("FAIL arst_restart_second: valid=%0b data=%0d want 1 41", valid_a, data_a);
        end
        stop_a = 1'b1;
        tick();
        stop_a = 1'b0;
        n = 0;
        while (busy_a === 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++;
            $display("FAIL arst_final_idle: busy=%0b want 0", busy_a);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        set_cfg(1'b0, 8'd0, 8'd0, 8'd0);
        start_a = 1'b0; stop_a = 1'b0; rdy_a = 1'b0;
        start_b = 1'b0; stop_b = 1'b0; rdy_b = 1'b0;
        start_c = 1'b0; stop_c = 1'b0; rdy_c = 1'b0;
        test_reset();
        test_continuous();
        test_one_shot();
        test_backpressure();
        test_stop_mid_run();
        test_full_pop();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
